vid_bus_master: RTL and testbench

- Bus initiator for the video CPU-side interface: drives the same address/write/data/read-data port the video block answers on (palette, sprite RAM, VRAM0/1, collision RAMs, scroll regs).
- Used by the MiSTer host side (ioctl/debug/state loader) to fill, stream-write or read back video memory.
- Arbitrates with the Z80 through a request/grant pair. While granted, it owns the video bus.

---
 rtl/vid_bus_pkg.sv | 28 ++
 rtl/vid_bus_addrgen.sv | 35 +++
 rtl/vid_bus_master.sv | 174 +++++++++++++++++
 tb/tb_vid_bus_master.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vid_bus_pkg.sv
// Shared definitions for the video-bus initiator: command opcodes, FSM states and the
// bus addresses of the video responder regions.
package vid_bus_pkg;

  localparam logic [1:0] OP_FILL  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  localparam logic [15:0] SPR_BASE     = 16'hD000;
  localparam logic [15:0] PAL_BASE     = 16'hD800;
  localparam logic [15:0] VRAM0_BASE   = 16'hE000;
  localparam logic [15:0] VRAM1_BASE   = 16'hE800;
  localparam logic [15:0] SCRREG_BASE  = 16'hEFBC;
  localparam logic [15:0] MIXCOLL_BASE = 16'hF000;
  localparam logic [15:0] SPRCOLL_BASE = 16'hF800;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StFill,
    StWstr,
    StRaddr,
    StRwait,
    StRpush,
    StFin
  } state_t;

endpackage

// File: rtl/vid_bus_addrgen.sv
// Address/byte-count register for one transfer: loads base and length, steps address+1 and
// count-1, and flags the final byte. The address wraps at 16 bits.
module vid_bus_addrgen #(
  parameter int unsigned LEN_W = 12
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [15:0]      base_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             step_i,
  output logic [15:0]      addr_o,
  output logic             last_o
);

  logic [15:0]      addr_q;
  logic [LEN_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= 16'h0000;
      cnt_q  <= '0;
    end else if (load_i) begin
      addr_q <= base_i;
      cnt_q  <= len_i;
    end else if (step_i) begin
      addr_q <= addr_q + 16'd1;
      cnt_q  <= cnt_q - LEN_W'(1);
    end
  end

  assign addr_o = addr_q;
  assign last_o = (cnt_q == LEN_W'(1));

endmodule

// File: rtl/vid_bus_master.sv
// Video-bus initiator: fills, stream-writes or reads back video memory while granted the bus.
// Define VBLANK_SYNC_EN to add a vblk input that holds off bus_req until vertical blank.
module vid_bus_master
  import vid_bus_pkg::*;
#(
  parameter int unsigned LEN_W  = 12,
  parameter int unsigned RD_LAT = 1
) (
`ifdef VBLANK_SYNC_EN
  input  logic             vblk,
`endif
  input  logic             cpu_cl,
  input  logic             RESET_N,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [15:0]      cmd_base,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [7:0]       cmd_data,
  input  logic             wd_valid,
  output logic             wd_ready,
  input  logic [7:0]       wd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [7:0]       rd_data,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             bus_req,
  input  logic             bus_gnt,
  output logic [15:0]      bus_ad,
  output logic             bus_wr,
  output logic [7:0]       bus_dw,
  input  logic             bus_rdok,
  input  logic [7:0]       bus_dr
);

  state_t      state_q;
  logic [1:0]  op_q;
  logic [7:0]  data_q;
  logic        err_q;
  logic        bus_req_q;
  logic [7:0]  rd_data_q;
  logic [7:0]  lat_q;
  logic        rdok_q;
  logic        load_ag;
  logic        step_ag;
  logic        last_ag;
  logic        vblk_ok;

`ifdef VBLANK_SYNC_EN
  assign vblk_ok = vblk;
`else
  assign vblk_ok = 1'b1;
`endif

  assign load_ag = (state_q == StIdle) && cmd_valid;

  always_comb begin
    step_ag = 1'b0;
    unique case (state_q)
      StFill:  step_ag = bus_gnt;
      StWstr:  step_ag = wd_valid & bus_gnt;
      StRpush: step_ag = rd_ready;
      default: step_ag = 1'b0;
    endcase
  end

  vid_bus_addrgen #(
    .LEN_W(LEN_W)
  ) u_addrgen (
    .clk_i  (cpu_cl),
    .rst_ni (RESET_N),
    .load_i (load_ag),
    .base_i (cmd_base),
    .len_i  (cmd_len),
    .step_i (step_ag),
    .addr_o (bus_ad),
    .last_o (last_ag)
  );

  always_ff @(posedge cpu_cl or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= StIdle;
      op_q      <= OP_FILL;
      data_q    <= 8'h00;
      err_q     <= 1'b0;
      bus_req_q <= 1'b0;
      rd_data_q <= 8'h00;
      lat_q     <= 8'h00;
      rdok_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            op_q   <= cmd_op;
            data_q <= cmd_data;
            err_q  <= (cmd_op == 2'b11);
            if ((cmd_len == '0) || (cmd_op == 2'b11)) begin
              state_q <= StFin;
            end else begin
              state_q   <= StReq;
              bus_req_q <= vblk_ok;
            end
          end
        end
        StReq: begin
          if (!bus_req_q) begin
            bus_req_q <= vblk_ok;
          end else if (bus_gnt) begin
            case (op_q)
              OP_FILL:  state_q <= StFill;
              OP_WRITE: state_q <= StWstr;
              default:  state_q <= StRaddr;
            endcase
          end
        end
        StFill, StWstr: begin
          if (step_ag && last_ag) begin
            state_q   <= StFin;
            bus_req_q <= 1'b0;
          end
        end
        StRaddr: begin
          if (bus_gnt) begin
            rdok_q  <= bus_rdok;
            lat_q   <= 8'h00;
            state_q <= StRwait;
          end
        end
        StRwait: begin
          // Losing the grant mid-read discards the access; RADDR re-issues the same address.
          if (!bus_gnt) begin
            state_q <= StRaddr;
          end else if (lat_q == 8'(RD_LAT - 1)) begin
            rd_data_q <= rdok_q ? bus_dr : 8'hFF;
            if (!rdok_q) err_q <= 1'b1;
            state_q <= StRpush;
          end else begin
            lat_q <= lat_q + 8'd1;
          end
        end
        StRpush: begin
          if (rd_ready) begin
            if (last_ag) begin
              state_q   <= StFin;
              bus_req_q <= 1'b0;
            end else begin
              state_q <= StRaddr;
            end
          end
        end
        StFin: begin
          err_q   <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StFin);
  assign err       = (state_q == StFin) && err_q;
  assign bus_req   = bus_req_q;
  assign wd_ready  = (state_q == StWstr) && bus_gnt;
  assign rd_valid  = (state_q == StRpush);
  assign rd_data   = rd_data_q;
  assign bus_wr    = ((state_q == StFill) && bus_gnt) || (wd_valid && wd_ready);
  assign bus_dw    = (state_q == StFill) ? data_q :
                     (state_q == StWstr) ? wd_data : 8'h00;

endmodule

// File: tb/tb_vid_bus_master.sv
// Directed bench for vid_bus_master: fill, stream write, reads with stall and region error,
// address wrap with grant loss, illegal/zero-length commands and asynchronous reset.
module tb_vid_bus_master;
  import vid_bus_pkg::*;

  logic        cpu_cl = 1'b0;
  logic        RESET_N;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_base;
  logic [11:0] cmd_len;
  logic [7:0]  cmd_data;
  logic        wd_valid, wd_ready;
  logic [7:0]  wd_data;
  logic        rd_valid, rd_ready;
  logic [7:0]  rd_data;
  logic        busy, done, err, bus_req, bus_gnt;
  logic [15:0] bus_ad;
  logic        bus_wr;
  logic [7:0]  bus_dw;
  logic        bus_rdok;
  logic [7:0]  bus_dr;
`ifdef VBLANK_SYNC_EN
  logic        vblk;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_n = 0;
  logic [15:0] wr_ad[$];
  logic [7:0]  wr_dw[$];
  int          wr_cyc[$];
  logic [7:0]  rmem[16];

  vid_bus_master #(.LEN_W(12), .RD_LAT(1)) dut (
`ifdef VBLANK_SYNC_EN
    .vblk      (vblk),
`endif
    .cpu_cl    (cpu_cl),
    .RESET_N   (RESET_N),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_base  (cmd_base),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .wd_valid  (wd_valid),
    .wd_ready  (wd_ready),
    .wd_data   (wd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .bus_req   (bus_req),
    .bus_gnt   (bus_gnt),
    .bus_ad    (bus_ad),
    .bus_wr    (bus_wr),
    .bus_dw    (bus_dw),
    .bus_rdok  (bus_rdok),
    .bus_dr    (bus_dr)
  );

  always #5 cpu_cl = ~cpu_cl;

  always @(posedge cpu_cl) cyc <= cyc + 1;

  // Synchronous responder, one cycle of read latency.
  always @(posedge cpu_cl) bus_dr <= rmem[bus_ad[3:0]];

  always @(negedge cpu_cl) begin
    if (bus_wr === 1'b1) begin
      wr_ad.push_back(bus_ad);
      wr_dw.push_back(bus_dw);
      wr_cyc.push_back(cyc);
    end
    if (done === 1'b1) done_n <= done_n + 1;
  end

  task automatic clk1;
    @(posedge cpu_cl);
    #2;
  endtask

  task automatic clear_log;
    wr_ad.delete();
    wr_dw.delete();
    wr_cyc.delete();
  endtask

  task automatic issue(input logic [1:0] op, input logic [15:0] base, input logic [11:0] len,
                       input logic [7:0] dat, output int acc, output logic rdy);
    cmd_op = op; cmd_base = base; cmd_len = len; cmd_data = dat; cmd_valid = 1'b1;
    @(negedge cpu_cl);
    acc = cyc;
    rdy = cmd_ready;
    clk1();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int c, output logic e);
    c = -1;
    e = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge cpu_cl);
      if (done === 1'b1) begin
        c = cyc;
        e = err;
        break;
      end
    end
    clk1();
  endtask

  task automatic wait_rd(output int n);
    n = -1;
    for (int i = 1; i <= 50; i++) begin
      @(negedge cpu_cl);
      if (rd_valid === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ok);
    wd_valid = 1'b1;
    wd_data = b;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge cpu_cl);
      ok = wd_ready;
      clk1();
      if (ok) break;
    end
    wd_valid = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge cpu_cl);
    checks++;
    if ({cmd_ready, wd_ready, rd_valid, busy, done, err, bus_req, bus_wr} !== 8'b1000_0000) begin
      errors++;
      $display("FAIL reset_flags got %b want 10000000",
               {cmd_ready, wd_ready, rd_valid, busy, done, err, bus_req, bus_wr});
    end
    checks++;
    if ({rd_data, bus_ad, bus_dw} !== 32'h0) begin
      errors++;
      $display("FAIL reset_data got %h want 0", {rd_data, bus_ad, bus_dw});
    end
    clk1();
  endtask

  task automatic test_fill;
    int acc, c;
    logic rdy, e;
    bus_gnt = 1'b1;
    clear_log();
    issue(OP_FILL, 16'hE000, 12'd4, 8'h5A, acc, rdy);
    checks++;
    if (rdy !== 1'b1) begin errors++; $display("FAIL fill_accept got %b want 1", rdy); end
    @(negedge cpu_cl);
    checks++;
    if ({bus_req, busy, bus_wr, cmd_ready} !== 4'b1100) begin
      errors++;
      $display("FAIL fill_req req/busy/wr/rdy got %b want 1100", {bus_req, busy, bus_wr, cmd_ready});
    end
    wait_done(c, e);
    checks++;
    if (wr_ad.size() != 4) begin
      errors++; $display("FAIL fill_count got %0d want 4", wr_ad.size());
    end
    for (int i = 0; i < wr_ad.size() && i < 4; i++) begin
      checks++;
      if ({wr_ad[i], wr_dw[i]} !== {16'hE000 + 16'(i), 8'h5A} || wr_cyc[i] != acc + 2 + i) begin
        errors++;
        $display("FAIL fill_wr%0d got %h=%h @%0d want %h=5A @%0d", i, wr_ad[i], wr_dw[i],
                 wr_cyc[i], 16'hE000 + 16'(i), acc + 2 + i);
      end
    end
    checks++;
    if (c != acc + 6 || e !== 1'b0) begin
      errors++; $display("FAIL fill_done got @%0d err %b want @%0d err 0", c, e, acc + 6);
    end
  endtask

  task automatic test_write;
    int acc, c;
    logic rdy, e, ok1, ok2, ok3;
    clear_log();
    issue(OP_WRITE, 16'hD800, 12'd3, 8'h00, acc, rdy);
    send_byte(8'h11, ok1);
    clk1();
    clk1();
    send_byte(8'h22, ok2);
    send_byte(8'h33, ok3);
    wait_done(c, e);
    checks++;
    if ({ok1, ok2, ok3} !== 3'b111 || wr_ad.size() != 3) begin
      errors++;
      $display("FAIL wstr_count hs %b writes %0d want 111 3", {ok1, ok2, ok3}, wr_ad.size());
    end
    if (wr_ad.size() == 3) begin
      checks++;
      if ({wr_ad[0], wr_dw[0], wr_ad[1], wr_dw[1], wr_ad[2], wr_dw[2]} !==
          {16'hD800, 8'h11, 16'hD801, 8'h22, 16'hD802, 8'h33}) begin
        errors++;
        $display("FAIL wstr_data got %h=%h %h=%h %h=%h want D800=11 D801=22 D802=33",
                 wr_ad[0], wr_dw[0], wr_ad[1], wr_dw[1], wr_ad[2], wr_dw[2]);
      end
      checks++;
      if (wr_cyc[1] - wr_cyc[0] != 3 || wr_cyc[2] - wr_cyc[1] != 1) begin
        errors++;
        $display("FAIL wstr_gap got %0d,%0d want 3,1", wr_cyc[1] - wr_cyc[0],
                 wr_cyc[2] - wr_cyc[1]);
      end
    end
    checks++;
    if (c < 0 || e !== 1'b0) begin errors++; $display("FAIL wstr_done got %0d err %b", c, e); end
  endtask

  task automatic test_read;
    int acc, c, n;
    logic rdy, e;
    clear_log();
    bus_rdok = 1'b1;
    rd_ready = 1'b0;
    issue(OP_READ, 16'hE800, 12'd2, 8'h00, acc, rdy);
    wait_rd(n);
    checks++;
    if (n != 4 || rd_data !== 8'h3C) begin
      errors++; $display("FAIL rd_first got n=%0d data %h want n=4 data 3C", n, rd_data);
    end
    clk1(); clk1(); clk1();
    @(negedge cpu_cl);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h3C) begin
      errors++; $display("FAIL rd_stall got valid %b data %h want 1 3C", rd_valid, rd_data);
    end
    rd_ready = 1'b1;
    clk1();
    rd_ready = 1'b0;
    wait_rd(n);
    checks++;
    if (n != 3 || rd_data !== 8'hC3) begin
      errors++; $display("FAIL rd_second got n=%0d data %h want n=3 data C3", n, rd_data);
    end
    rd_ready = 1'b1;
    clk1();
    rd_ready = 1'b0;
    wait_done(c, e);
    checks++;
    if (c < 0 || e !== 1'b0 || wr_ad.size() != 0) begin
      errors++;
      $display("FAIL rd_done got %0d err %b writes %0d want err 0 writes 0", c, e, wr_ad.size());
    end
  endtask

  task automatic test_read_err;
    int acc, c, n;
    logic rdy, e;
    bus_rdok = 1'b0;
    issue(OP_READ, 16'h0000, 12'd1, 8'h00, acc, rdy);
    wait_rd(n);
    checks++;
    if (n != 4 || rd_data !== 8'hFF) begin
      errors++; $display("FAIL rderr_data got n=%0d data %h want n=4 data FF", n, rd_data);
    end
    rd_ready = 1'b1;
    clk1();
    rd_ready = 1'b0;
    wait_done(c, e);
    checks++;
    if (c < 0 || e !== 1'b1) begin errors++; $display("FAIL rderr_done got %0d err %b", c, e); end
    bus_rdok = 1'b1;
  endtask

  task automatic test_fill_wrap;
    int acc, c;
    logic rdy, e;
    clear_log();
    issue(OP_FILL, 16'hFFFF, 12'd2, 8'h77, acc, rdy);
    clk1();
    clk1();
    bus_gnt = 1'b0;
    @(negedge cpu_cl);
    checks++;
    if ({bus_wr, bus_req, busy} !== 3'b011 || bus_ad !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_drop got wr/req/busy %b ad %h want 011 0000", {bus_wr, bus_req, busy},
               bus_ad);
    end
    clk1();
    clk1();
    bus_gnt = 1'b1;
    wait_done(c, e);
    checks++;
    if (wr_ad.size() != 2) begin errors++; $display("FAIL wrap_count got %0d want 2", wr_ad.size());
    end
    if (wr_ad.size() == 2) begin
      checks++;
      if ({wr_ad[0], wr_dw[0], wr_ad[1], wr_dw[1]} !== {16'hFFFF, 8'h77, 16'h0000, 8'h77} ||
          wr_cyc[0] != acc + 2 || wr_cyc[1] != acc + 5) begin
        errors++;
        $display("FAIL wrap_wr got %h=%h @%0d %h=%h @%0d want FFFF=77 @%0d 0000=77 @%0d",
                 wr_ad[0], wr_dw[0], wr_cyc[0], wr_ad[1], wr_dw[1], wr_cyc[1], acc + 2, acc + 5);
      end
    end
    checks++;
    if (c != acc + 6 || e !== 1'b0) begin
      errors++; $display("FAIL wrap_done got @%0d err %b want @%0d err 0", c, e, acc + 6);
    end
  endtask

  task automatic test_illegal;
    int acc;
    logic rdy;
    clear_log();
    issue(2'b11, 16'h1234, 12'd5, 8'h00, acc, rdy);
    @(negedge cpu_cl);
    checks++;
    if ({done, err, bus_req} !== 3'b110) begin
      errors++; $display("FAIL illegal_op done/err/req got %b want 110", {done, err, bus_req});
    end
    clk1();
    issue(OP_FILL, 16'hE000, 12'd0, 8'h12, acc, rdy);
    @(negedge cpu_cl);
    checks++;
    if ({done, err, bus_req} !== 3'b100) begin
      errors++; $display("FAIL zero_len done/err/req got %b want 100", {done, err, bus_req});
    end
    clk1();
    @(negedge cpu_cl);
    checks++;
    if ({busy, cmd_ready} !== 2'b01 || wr_ad.size() != 0) begin
      errors++;
      $display("FAIL zero_idle busy/rdy %b writes %0d want 01 0", {busy, cmd_ready}, wr_ad.size());
    end
    clk1();
  endtask

  task automatic test_reset_mid;
    int acc, dn;
    logic rdy;
    clear_log();
    dn = done_n;
    issue(OP_FILL, 16'hE000, 12'd8, 8'hA5, acc, rdy);
    clk1();
    clk1();
    clk1();
    @(negedge cpu_cl);
    #1;
    RESET_N = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, busy, done, err, bus_req, bus_wr, wd_ready, rd_valid} !== 8'b1000_0000 ||
        {bus_ad, bus_dw} !== 24'h0) begin
      errors++;
      $display("FAIL rst_async got %b ad %h dw %h want 10000000 0000 00",
               {cmd_ready, busy, done, err, bus_req, bus_wr, wd_ready, rd_valid}, bus_ad, bus_dw);
    end
    clk1();
    clk1();
    RESET_N = 1'b1;
    clk1();
    clk1();
    checks++;
    if (wr_ad.size() != 3 || done_n != dn || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_abort writes %0d dones %0d busy %b want 3 0 0", wr_ad.size(),
               done_n - dn, busy);
    end
  endtask

`ifdef VBLANK_SYNC_EN
  task automatic test_vblank;
    int acc, c;
    logic rdy, e;
    clear_log();
    vblk = 1'b0;
    issue(OP_FILL, 16'hF000, 12'd1, 8'h99, acc, rdy);
    repeat (3) begin
      @(negedge cpu_cl);
      checks++;
      if ({bus_req, bus_wr} !== 2'b00) begin
        errors++; $display("FAIL vblk_hold req/wr got %b want 00", {bus_req, bus_wr});
      end
      clk1();
    end
    vblk = 1'b1;
    clk1();
    vblk = 1'b0;
    @(negedge cpu_cl);
    checks++;
    if (bus_req !== 1'b1) begin errors++; $display("FAIL vblk_req got %b want 1", bus_req); end
    wait_done(c, e);
    checks++;
    if (wr_ad.size() != 1 || c < 0) begin
      errors++; $display("FAIL vblk_xfer writes %0d done %0d want 1", wr_ad.size(), c);
    end
    vblk = 1'b1;
  endtask
`endif

  initial begin
    for (int i = 0; i < 16; i++) rmem[i] = 8'(i);
    rmem[0] = 8'h3C;
    rmem[1] = 8'hC3;
    RESET_N = 1'b0;
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_base = 16'h0; cmd_len = 12'h0; cmd_data = 8'h0;
    wd_valid = 1'b0; wd_data = 8'h0; rd_ready = 1'b0;
    bus_gnt = 1'b1; bus_rdok = 1'b1;
`ifdef VBLANK_SYNC_EN
    vblk = 1'b1;
`endif
    clk1();
    clk1();
    RESET_N = 1'b1;
    clk1();
    test_reset();
    test_fill();
    test_write();
    test_read();
    test_read_err();
    test_fill_wrap();
    test_illegal();
    test_reset_mid();
`ifdef VBLANK_SYNC_EN
    test_vblank();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
